// File: rtl/hdmi_clkgen_pkg.sv
// hdmi_clkgen shared constants and helpers.
// Sizing and rate-clamp functions used by every file of the block.
package hdmi_clkgen_pkg;

  function automatic int acc_width(input int clk_hz);
    return $clog2(clk_hz) + 1;
  endfunction

  function automatic int hz_max(input int clk_hz);
    return (clk_hz - 1) / 2;
  endfunction

  function automatic int hz_clamp(input int hz, input int clk_hz);
    return (hz > hz_max(clk_hz)) ? hz_max(clk_hz) : hz;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hdmi_clkgen_multi_if.sv
// Config and status bundle of the multi-channel clock generator.
// master drives config, slave is the generator.
interface hdmi_clkgen_multi_if
  import hdmi_clkgen_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int HZ_W     = 24
);
  localparam int CH_W = idx_width(CHANNELS);

  logic                     cfg_we;
  logic [CH_W-1:0]          cfg_ch;
  logic [HZ_W-1:0]          cfg_hz;
  logic                     cfg_sync;
  logic [CHANNELS-1:0]      ch_clk;
  logic [CHANNELS-1:0]      ch_ena;
  logic [CHANNELS*HZ_W-1:0] meas_hz;
  logic                     meas_valid;

  modport master (
    output cfg_we, cfg_ch, cfg_hz, cfg_sync,
    input  ch_clk, ch_ena, meas_hz, meas_valid
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_hz, cfg_sync,
    output ch_clk, ch_ena, meas_hz, meas_valid
  );

endinterface

// File: rtl/hdmi_clkgen_chan.sv
// One fractional clock channel: modulo accumulator, rate register,
// clock/enable outputs and saturating enable counter for the meter.
module hdmi_clkgen_chan
  import hdmi_clkgen_pkg::*;
#(
  parameter int CLK_HZ     = 74250000,
  parameter int HZ_W       = 24,
  parameter int DEFAULT_HZ = 48000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [HZ_W-1:0] wr_hz,
  input  logic            sync,
  input  logic            tick,
  output logic            ch_clk,
  output logic            ch_ena,
  output logic [HZ_W-1:0] cnt_sum
);
  localparam int ACC_W = acc_width(CLK_HZ);
  localparam int SUM_W = ACC_W + 1;
  localparam logic [SUM_W-1:0] MOD = SUM_W'(CLK_HZ);
  localparam logic [HZ_W-1:0] RST_HZ =
    HZ_W'(hz_clamp(DEFAULT_HZ, CLK_HZ));

  logic [ACC_W-1:0] acc;
  logic [HZ_W-1:0]  hz;
  logic [HZ_W-1:0]  cnt;
  logic [SUM_W-1:0] sum;
  logic             wrap;

  // 2*hz per cycle against CLK_HZ: one crossing per half period
  assign sum     = SUM_W'(acc) + SUM_W'({hz, 1'b0});
  assign wrap    = sum >= MOD;
  assign cnt_sum = (&cnt) ? cnt : cnt + HZ_W'(ch_ena);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      ch_clk <= 1'b0;
      ch_ena <= 1'b0;
    end else if (sync) begin
      acc    <= '0;
      ch_clk <= 1'b0;
      ch_ena <= 1'b0;
    end else if (wrap) begin
      acc    <= ACC_W'(sum - MOD);
      ch_clk <= ~ch_clk;
      ch_ena <= ~ch_clk;
    end else begin
      acc    <= ACC_W'(sum);
      ch_ena <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hz <= RST_HZ;
    else if (we) hz <= wr_hz;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt_sum;
  end

endmodule

// File: rtl/hdmi_clkgen_multi.sv
// Multi-channel fractional clock/enable generator with gated meter.
// Top: config decode, gate counter and measurement packing.
module hdmi_clkgen_multi
  import hdmi_clkgen_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CLK_HZ      = 74250000,
  parameter int HZ_W        = 24,
  parameter int DEFAULT_HZ  = 48000,
  parameter int GATE_CYCLES = CLK_HZ
) (
  input logic                clk,
  input logic                reset,
  hdmi_clkgen_multi_if.slave bus
);
  localparam int G_W = idx_width(GATE_CYCLES);
  localparam logic [G_W-1:0] G_LAST = G_W'(GATE_CYCLES - 1);

  logic [G_W-1:0]           gate;
  logic                     tick;
  logic [HZ_W-1:0]          wr_hz;
  logic [CHANNELS-1:0]      clk_v;
  logic [CHANNELS-1:0]      ena_v;
  logic [HZ_W-1:0]          cnt_sum [CHANNELS];
  logic [CHANNELS*HZ_W-1:0] meas;
  logic                     valid;

  assign tick  = gate == G_LAST;
  assign wr_hz = HZ_W'(hz_clamp(32'(bus.cfg_hz), CLK_HZ));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate  <= '0;
      meas  <= '0;
      valid <= 1'b0;
    end else begin
      gate  <= tick ? '0 : gate + G_W'(1);
      valid <= tick;
      if (tick)
        for (int c = 0; c < CHANNELS; c++)
          meas[c*HZ_W +: HZ_W] <= cnt_sum[c];
    end
  end

  // out-of-range indices match no channel, so the write drops
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic we_c;
    assign we_c = bus.cfg_we && (32'(bus.cfg_ch) == 32'(c));

    hdmi_clkgen_chan #(
      .CLK_HZ     (CLK_HZ),
      .HZ_W       (HZ_W),
      .DEFAULT_HZ (DEFAULT_HZ)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .we      (we_c),
      .wr_hz   (wr_hz),
      .sync    (bus.cfg_sync),
      .tick    (tick),
      .ch_clk  (clk_v[c]),
      .ch_ena  (ena_v[c]),
      .cnt_sum (cnt_sum[c])
    );
  end

  assign bus.ch_clk     = clk_v;
  assign bus.ch_ena     = ena_v;
  assign bus.meas_hz    = meas;
  assign bus.meas_valid = valid;

endmodule

// File: tb/tb_hdmi_clkgen_multi.sv
// Bench for hdmi_clkgen_multi: phase-count reference model, rate table,
// random retunes and hand-written sync/retune/reset sequences.
module tb_hdmi_clkgen_multi;
  import hdmi_clkgen_pkg::*;

  localparam int CH     = 3;
  localparam int CLK_HZ = 1000;
  localparam int HZ_W   = 24;
  localparam int DEF_HZ = 48;
  localparam int GATE   = 1000;
  localparam int HZ_MAX = (CLK_HZ - 1) / 2;
  localparam int CH_W   = idx_width(CH);

  logic clk = 1'b0;
  logic reset = 1'b1;

  hdmi_clkgen_multi_if #(.CHANNELS(CH), .HZ_W(HZ_W)) bus ();

  hdmi_clkgen_multi #(
    .CHANNELS    (CH),
    .CLK_HZ      (CLK_HZ),
    .HZ_W        (HZ_W),
    .DEFAULT_HZ  (DEF_HZ),
    .GATE_CYCLES (GATE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int ncyc = 0;

  // model: running phase sum; crossings = phase / CLK_HZ
  longint m_phase [CH];
  int     m_hz    [CH];
  bit     m_clk   [CH];
  bit     m_ena   [CH];
  int     m_win   [CH];
  int     m_meas  [CH];
  bit     m_valid;
  int     m_gidx;

  typedef struct {
    int h0; int h1; int h2; bit sy;
    int e0; int e1; int e2;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int clampv(input int hz);
    return (hz > HZ_MAX) ? HZ_MAX : hz;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_phase[c] = 0;
      m_hz[c]    = clampv(DEF_HZ);
      m_clk[c]   = 1'b0;
      m_ena[c]   = 1'b0;
      m_win[c]   = 0;
      m_meas[c]  = 0;
    end
    m_valid = 1'b0;
    m_gidx  = 0;
  endfunction

  function automatic void model_edge(input bit we, input int ch,
                                     input int hz, input bit sy);
    longint n0, n1;
    for (int c = 0; c < CH; c++) begin
      if (m_gidx == GATE - 1) begin
        m_meas[c] = m_win[c] + int'(m_ena[c]);
        m_win[c]  = 0;
      end else begin
        m_win[c] += int'(m_ena[c]);
      end
    end
    m_valid = (m_gidx == GATE - 1);
    m_gidx  = (m_gidx + 1) % GATE;
    for (int c = 0; c < CH; c++) begin
      if (sy) begin
        m_phase[c] = 0;
        m_clk[c]   = 1'b0;
        m_ena[c]   = 1'b0;
      end else begin
        n0 = m_phase[c] / CLK_HZ;
        m_phase[c] += 2 * m_hz[c];
        n1 = m_phase[c] / CLK_HZ;
        m_clk[c] = n1[0];
        m_ena[c] = (n1 != n0) && n1[0];
      end
    end
    if (we && ch < CH) m_hz[ch] = clampv(hz);
  endfunction

  task automatic check_outputs();
    logic [CH-1:0]      ec, ee;
    logic [CH*HZ_W-1:0] em;
    for (int c = 0; c < CH; c++) begin
      ec[c] = m_clk[c];
      ee[c] = m_ena[c];
      em[c*HZ_W +: HZ_W] = HZ_W'(m_meas[c]);
    end
    check("ch_clk", 128'(bus.ch_clk), 128'(ec));
    check("ch_ena", 128'(bus.ch_ena), 128'(ee));
    check("meas_valid", 128'(bus.meas_valid), 128'(m_valid));
    check("meas_hz", 128'(bus.meas_hz), 128'(em));
  endtask

  task automatic cyc(input bit we = 1'b0, input int ch = 0,
                     input int hz = 0, input bit sy = 1'b0);
    bus.cfg_we   = we;
    bus.cfg_ch   = CH_W'(ch);
    bus.cfg_hz   = HZ_W'(hz);
    bus.cfg_sync = sy;
    @(posedge clk);
    model_edge(we, ch, hz, sy);
    #1;
    check_outputs();
    ncyc++;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
    bus.cfg_sync = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.meas_valid && n < 3 * GATE);
    check("valid_seen", 128'(bus.meas_valid), 128'(1));
  endtask

  task automatic align(input int k);
    int n;
    n = 0;
    while (m_gidx != k && n < 2 * GATE) begin
      cyc();
      n++;
    end
  endtask

  task automatic check_meas(input string nm, input int c, input int e);
    check(nm, 128'(bus.meas_hz[c*HZ_W +: HZ_W]), 128'(e));
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_clk"}, 128'(bus.ch_clk), 128'(0));
    check({nm, "_ena"}, 128'(bus.ch_ena), 128'(0));
    check({nm, "_meas"}, 128'(bus.meas_hz), 128'(0));
    check({nm, "_valid"}, 128'(bus.meas_valid), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    int n, last, tog, h[3], u;
    bit prev, sy;

    tbl[0] = '{48,  441,  0,   1'b1, 48,  441, 0};
    tbl[1] = '{600, 499,  1,   1'b0, 499, 499, 1};
    tbl[2] = '{96,  32,   250, 1'b1, 96,  32,  250};
    tbl[3] = '{0,   1000, 5,   1'b0, 0,   499, 5};

    bus.cfg_we   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_hz   = '0;
    bus.cfg_sync = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // first gate after reset runs at the default rate
    wait_valid(n);
    check("first_valid_lat", 128'(n), 128'(GATE));
    for (int c = 0; c < CH; c++) check_meas("meas_default", c, DEF_HZ);

    for (int i = 0; i < 4; i++) begin
      align(GATE - 5);
      cyc(1'b1, 0, tbl[i].h0);
      cyc(1'b1, 1, tbl[i].h1);
      cyc(1'b1, 3, 77);
      cyc(1'b1, 2, tbl[i].h2, tbl[i].sy);
      wait_valid(n);
      wait_valid(n);
      check("gate_period", 128'(n), 128'(GATE));
      check_meas("tbl_ch0", 0, tbl[i].e0);
      check_meas("tbl_ch1", 1, tbl[i].e1);
      check_meas("tbl_ch2", 2, tbl[i].e2);
    end

    // sync drops every channel at the same edge
    cyc(1'b1, 0, 48);
    cyc(1'b1, 1, 441);
    repeat (37) cyc();
    cyc(1'b0, 0, 0, 1'b1);
    check("sync_clk", 128'(bus.ch_clk), 128'(0));
    check("sync_ena", 128'(bus.ch_ena), 128'(0));

    // enable spacing at 48 Hz of 1000
    last = -1;
    for (int i = 0; i < 1100; i++) begin
      cyc();
      if (bus.ch_ena[0]) begin
        if (last >= 0) begin
          vecs++;
          if (!((ncyc - last) inside {20, 21})) begin
            errs++;
            $display("FAIL ena_period: got %0d want 20 or 21",
                     ncyc - last);
          end
        end
        last = ncyc;
      end
    end

    // clamped rate toggles 998 times per 1000 cycles
    cyc(1'b1, 0, 600);
    prev = bus.ch_clk[0];
    tog = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (bus.ch_clk[0] != prev) tog++;
      prev = bus.ch_clk[0];
    end
    check("toggles_499", 128'(tog), 128'(998));

    // retune mid-gate without sync
    cyc(1'b1, 0, 48);
    align(500);
    cyc(1'b1, 0, 96);
    wait_valid(n);
    wait_valid(n);
    check_meas("retune_96", 0, 96);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 1000; i++) begin
        u = $urandom_range(0, 199);
        if (u < 4)
          cyc(1'b1, $urandom_range(0, 3), $urandom_range(0, 700));
        else if (u == 4)
          cyc(1'b0, 0, 0, 1'b1);
        else
          cyc();
      end
      for (int c = 0; c < 3; c++) h[c] = $urandom_range(0, 700);
      sy = 1'($urandom_range(0, 1));
      align(GATE - 4);
      cyc(1'b1, 0, h[0]);
      cyc(1'b1, 1, h[1]);
      cyc(1'b1, 2, h[2], sy);
      wait_valid(n);
      wait_valid(n);
      for (int c = 0; c < CH; c++)
        check_meas("rand_meas", c, clampv(h[c]));
    end

    // asynchronous reset part-way through a gate
    align(537);
    #1;
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_valid(n);
    check("reset_valid_lat", 128'(n), 128'(GATE));
    for (int c = 0; c < CH; c++) check_meas("post_reset", c, DEF_HZ);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hdmi_clkgen_multi.md
# hdmi_clkgen_multi

Multi-channel fractional clock/enable generator running in the HDMI pixel clock domain, the successor to the single audio-clock generator inside the HDMI PLL wrapper. Each channel synthesises an exact-average clock at a runtime-programmable integer Hz from the pixel clock using a modulo-CLK_HZ accumulator (zero long-term drift). It also provides a one-cycle sample-enable pulse. A built-in gated frequency meter reports the true delivered rate of every channel. Typical use: audio sample clocks (32k/44.1k/48k) plus auxiliary low-rate ticks for the HDMI/audio pipeline.

## Interface
- CHANNELS, 4, number of independent generators (1..16)
- CLK_HZ, 74250000, exact frequency of clk in Hz
- HZ_W, 24, width of programmed/measured rates
- DEFAULT_HZ, 48000, rate loaded into every channel at reset
- GATE_CYCLES, CLK_HZ, meter gate length in clk cycles (1 s by default)

- clk  in  1  pixel clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- cfg_we  in  1  write strobe for one channel's rate
- cfg_ch  in  $clog2(CHANNELS) (min 1)  channel index for cfg_we
- cfg_hz  in  HZ_W  requested rate in Hz
- cfg_sync  in  1  phase-align strobe, all channels
- ch_clk  out  CHANNELS  synthesised clocks, ~50% duty
- ch_ena  out  CHANNELS  one-cycle pulse per ch_clk rising edge
- meas_hz  out  CHANNELS*HZ_W  ena count of last complete gate, channel c at [c*HZ_W +: HZ_W]
- meas_valid  out  1  one-cycle pulse when meas_hz updates

## Operation
- Constants: ACC_W = $clog2(CLK_HZ)+1; HZ_MAX = (CLK_HZ-1)/2 (integer divide).
- Rate register per channel; cfg_hz > HZ_MAX is clamped to HZ_MAX on write. cfg_ch >= CHANNELS: write ignored.
- Each cycle per channel: sum = acc + 2*hz (ACC_W+1 bits). If sum >= CLK_HZ: acc <= sum - CLK_HZ, ch_clk <= ~ch_clk, ch_ena <= ~ch_clk (pulse only on the 0->1 toggle). Otherwise: acc <= sum, ch_ena <= 0.
- Clamp guarantees at most one crossing per cycle and a minimum half-period of 1 cycle.
- hz = 0: accumulator frozen, ch_clk holds its level, no ena.
- Rate change does not clear acc or ch_clk (glitch-free retune; the new rate applies from the next add).
- cfg_sync: all acc <= 0, ch_clk <= 0, ch_ena <= 0 for every channel. It overrides the accumulate step that cycle. Rate registers are untouched.
- cfg_we and cfg_sync in the same cycle: both take effect.
- Meter: gate counter 0..GATE_CYCLES-1 free-running, not affected by cfg_sync. Per-channel ena counters are HZ_W wide and saturating.
- At the terminal gate cycle: meas_hz[c] <= cnt[c] + ch_ena[c] (saturating), cnt[c] <= 0, meas_valid <= 1.

## Timing
- Reset values: acc=0, hz=min(DEFAULT_HZ,HZ_MAX), ch_clk=0, ch_ena=0, meas_hz=0, meas_valid=0, gate counter=0, ena counters=0.
- Config latency: cfg_we at edge n sets hz at edge n. The first accumulate using the new rate happens at edge n+1.
- ch_ena and ch_clk are both registered and rise on the same edge, so ena is high during the first cycle of ch_clk high.
- Sync latency: cfg_sync at edge n forces outputs low from edge n. The first possible crossing is at edge n+1 or later.
- meas_valid is high for exactly one cycle, every GATE_CYCLES cycles. The first pulse comes GATE_CYCLES cycles after reset release.
- ch_clk half-period is floor or ceil of CLK_HZ/(2*hz) cycles. The average over any CLK_HZ cycles from sync is exact.
- Reset mid-operation clears everything asynchronously. There is no partial measurement.

## Structure
- Package hdmi_clkgen_pkg: function acc_width(clk_hz), function hz_clamp(hz, clk_hz), and a channel-index width helper.
- Sub-module hdmi_clkgen_chan: one accumulator, rate register, ch_clk/ch_ena and ena counter. It is instantiated CHANNELS times via generate.
- The top level holds config decode, the gate counter and meas_hz packing.

## Test plan
- CLK_HZ=1000, GATE_CYCLES=1000, ch0 hz=48 -> ch_ena period is always 20 or 21 cycles, and meas_hz[0]=48 on every meas_valid after the first full gate.
- Write hz=600 (> HZ_MAX=499) -> channel runs at 499. ch_clk toggles on 998 of 1000 cycles, and meas_hz=499.
- ch0=48, ch1=441, ch2=0, then pulse cfg_sync -> all ch_clk go low at the same edge. ch2 never toggles and meas_hz[2]=0. ch1 reports 441.
- Retune ch0 48->96 mid-gate without sync -> no ch_clk pulse shorter than 1 cycle and no double toggle. The next full gate reports 96.
- Assert reset at cycle 537 of a gate -> all outputs are 0 immediately. The next meas_valid comes 1000 cycles after release, and counters restart with no stale values.
- Default params, CLK_HZ=74250000, DEFAULT_HZ=48000, 1 s simulated -> meas_hz[0..3]=48000 exactly.
